mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Multi-cycle load/store unit for the MEM stage of the MIPS32 pipeline.
- Replaces single-cycle combinational memory access with a request/acknowledge bus handshake to a data bus of variable latency.
- Covers byte, halfword, word, LL and SC accesses; formats load data for write-back; stalls the pipeline while a transaction is outstanding.
- Adds alignment exceptions, a bus-timeout error, flush handling and an internally held LLbit.

Parameters:
- ADDR_W, 32: width of address inputs and bus_addr_o.
- TIMEOUT, 16: number of BUSY cycles without bus_ack_i before a bus error is raised; 0 disables the timeout.
- LL_ENABLE, 1: when 0, LL behaves as LW, SC behaves as SW and returns 1, and llbit_o stays 0.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- valid_i  in  1  EX/MEM holds an instruction.
- op_i  in  4  access type: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW, 9 LL, 10 SC; 11-15 are treated as NONE.
- addr_i  in  ADDR_W  effective address.
- reg2_i  in  32  store data.
- wd_i  in  5  destination register.
- wreg_i  in  1  register write enable.
- flush_i  in  1  pipeline flush.
- llbit_clr_i  in  1  clears LLbit (ERET/exception).
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write enable.
- bus_addr_o  out  ADDR_W  word-aligned bus address.
- bus_sel_o  out  4  byte lane selects.
- bus_wdata_o  out  32  bus write data.
- bus_rdata_i  in  32  bus read data.
- bus_ack_i  in  1  bus acknowledge.
- stall_o  out  1  pipeline stall request.
- done_o  out  1  one-cycle pulse when an access completes.
- wd_o  out  5  write-back register address.
- wreg_o  out  1  write-back enable.
- wdata_o  out  32  write-back data.
- adel_o  out  1  load address error pulse.
- ades_o  out  1  store address error pulse.
- berr_o  out  1  bus error pulse.
- llbit_o  out  1  current LLbit.

Behaviour:
- Reset: every output and all state is 0, and the FSM is in IDLE.
- States: IDLE, BUSY, RESP.
- Lane mapping (big-endian):
  - offset 0 → sel 1000, data[31:24]; offset 3 → sel 0001, data[7:0].
  - halfword offset 0 → sel 1100, data[31:16]; offset 2 → sel 0011, data[15:0].
  - word → sel 1111.
  - Store data is replicated across lanes: SB {4{b}}, SH {2{h}}.
  - bus_addr_o = {addr[ADDR_W-1:2], 2'b00}.
- IDLE, when valid_i=1, flush_i=0 and op≠NONE (accept):
  - stall_o=1 combinationally.
  - Misaligned access: halfword with addr[0]≠0, or word/LL/SC with addr[1:0]≠0.
    - Go to RESP; the next cycle pulses adel_o (loads, LL) or ades_o (stores, SC).
    - In that cycle wreg_o=0 and done_o=0; no bus activity.
  - SC with LLbit=0: go to RESP; no bus activity; result wdata_o=0 with wreg_o=wreg_i.
  - Otherwise: latch op, address, lanes, data, wd and wreg into registers, and go to BUSY with bus_req_o=1 from the next cycle.
- BUSY:
  - stall_o=1.
  - bus_req_o, bus_we_o, bus_addr_o, bus_sel_o and bus_wdata_o are held stable until the cycle bus_ack_i=1 is sampled.
  - On ack:
    - Drop bus_req_o the next cycle and go to RESP.
    - Register load data: sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW/LL, 32'd1 for SC.
    - wreg_o = latched wreg for loads, LL and SC; 0 for SB/SH/SW.
  - The timeout counter increments each BUSY cycle without ack. When it reaches TIMEOUT-1:
    - Drop bus_req_o and go to RESP.
    - RESP pulses berr_o=1 with wreg_o=0 and done_o=0.
  - Ack in the same cycle as the timeout count: ack wins.
- RESP:
  - Lasts one cycle; stall_o=0; done_o=1 unless it is an error or killed response; then return to IDLE.
  - valid_i is ignored in RESP, because it still shows the instruction just completed.
- Flush:
  - flush_i in IDLE blocks acceptance.
  - flush_i in BUSY sets a kill flag: the bus transaction still completes or times out (no abort). RESP then has wreg_o=0, done_o=0, berr_o=0, and LLbit is unchanged.
  - The kill flag clears on entry to IDLE.
- LLbit:
  - Set on a completed, non-killed LL; cleared on a completed, non-killed successful SC.
  - llbit_clr_i has priority over set in the same cycle.
  - llbit_o is the registered value.
- wd_o and wdata_o hold their last values outside RESP; consumers qualify them with wreg_o and done_o.
- Reset asserted mid-transaction: immediately return to IDLE with bus_req_o=0, all outputs 0 and LLbit=0.

Test Plan:
- LB at addr 0x101, bus_rdata_i=0x11F23344, ack after 3 cycles:
  - bus_sel_o=0100, bus_addr_o=0x100, stall_o high for 4 cycles.
  - RESP: wdata_o=0xFFFFFFF2, wreg_o=1, done_o=1.
- SH at 0x202 with reg2_i=0x0000ABCD, ack after 1 cycle: bus_we_o=1, bus_sel_o=0011, bus_wdata_o=0xABCDABCD, wreg_o=0.
- LW at 0x003: no bus_req_o; next cycle adel_o=1, done_o=0, wreg_o=0, stall_o=0.
- LL at 0x40 then SC at 0x40: llbit_o=1 after LL; SC issues a write and returns wdata_o=1; llbit_o=0 afterwards.
- Second SC with no new LL: no bus request; wdata_o=0.
- LW with bus_ack_i never asserted, TIMEOUT=16: bus_req_o high for exactly 16 cycles, then berr_o pulse, wreg_o=0.
- LW with flush_i pulsed in BUSY, then ack: done_o=0, wreg_o=0, FSM returns to IDLE.
- rst asserted during BUSY: bus_req_o=0 immediately, llbit_o=0.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: multi-cycle MIPS32 MEM-stage load/store unit with a request/acknowledge data bus
// Ports:
//   clk, rst            clock; asynchronous active-low reset (rst=0 resets)
//   valid_i, op_i       EX/MEM instruction valid and access type (LB..SC, 11-15 = NONE)
//   addr_i, reg2_i      effective address and store data
//   wd_i, wreg_i        destination register and write enable
//   flush_i             pipeline flush; llbit_clr_i clears LLbit
//   bus_*               request/ack data bus (word-aligned address, big-endian byte lanes)
//   stall_o, done_o     pipeline stall request and completion pulse
//   wd_o, wreg_o, wdata_o  write-back register, enable and formatted load data
//   adel_o, ades_o, berr_o load/store alignment error and bus timeout pulses
//   llbit_o             current LLbit
module mem_lsu #(
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT   = 16,
    parameter bit LL_ENABLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic              flush_i,
    input  logic              llbit_clr_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [31:0]       bus_wdata_o,
    input  logic [31:0]       bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic              berr_o,
    output logic              llbit_o
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] op, op_q;
    logic [1:0] off_q;
    logic [4:0] wd_q;
    logic wreg_q, kill_q, llbit_q;
    logic [CW-1:0] cnt_q;
    logic is_b, is_h, is_w, is_st, st_q, mis, sc_fail, accept, tmo, kill, ack_ok;
    logic [3:0] sel;
    logic [31:0] wdat, ld;
    logic [7:0] rb;
    logic [15:0] rh;

    assign op      = op_i > 4'd10 ? 4'd0 : op_i;
    assign is_b    = op == 4'd1 || op == 4'd2 || op == 4'd6;
    assign is_h    = op == 4'd3 || op == 4'd4 || op == 4'd7;
    assign is_w    = op == 4'd5 || op >= 4'd8;
    assign is_st   = op inside {4'd6, 4'd7, 4'd8, 4'd10};
    assign mis     = (is_h && addr_i[0]) || (is_w && addr_i[1:0] != 2'b00);
    assign sc_fail = LL_ENABLE && op == 4'd10 && !llbit_q;
    assign accept  = rst && state == IDLE && valid_i && !flush_i && op != 4'd0;
    assign sel     = is_b ? 4'b1000 >> addr_i[1:0] : is_h ? (addr_i[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    assign wdat    = is_b ? {4{reg2_i[7:0]}} : is_h ? {2{reg2_i[15:0]}} : reg2_i;
    // Timeout fires on the TIMEOUT-th BUSY cycle without ack; a coincident ack takes precedence.
    assign tmo     = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1) && !bus_ack_i;
    // A flush seen in the completing cycle kills the response just like an earlier one.
    assign kill    = kill_q || flush_i;
    assign st_q    = op_q inside {4'd6, 4'd7, 4'd8};
    assign ack_ok  = state == BUSY && bus_ack_i && !kill;
    assign rb      = bus_rdata_i[{~off_q, 3'b000} +: 8];
    assign rh      = off_q[1] ? bus_rdata_i[15:0] : bus_rdata_i[31:16];
    assign ld      = op_q == 4'd1  ? {{24{rb[7]}}, rb} :
                     op_q == 4'd2  ? {24'd0, rb} :
                     op_q == 4'd3  ? {{16{rh[15]}}, rh} :
                     op_q == 4'd4  ? {16'd0, rh} :
                     op_q == 4'd10 ? 32'd1 : bus_rdata_i;
    assign bus_req_o = state == BUSY;
    assign bus_we_o  = state == BUSY && (st_q || op_q == 4'd10);
    assign llbit_o   = llbit_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        stall_o  = 1'b0;
        case (state)
            IDLE: begin
                stall_o = accept;
                if (accept) state_nx = mis || sc_fail ? RESP : BUSY;
            end
            BUSY: begin
                stall_o = 1'b1;
                if (bus_ack_i || tmo) state_nx = RESP;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q        <= '0;
            off_q       <= '0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            kill_q      <= 1'b0;
            cnt_q       <= '0;
            llbit_q     <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
            done_o      <= 1'b0;
            wreg_o      <= 1'b0;
            wd_o        <= '0;
            wdata_o     <= '0;
            adel_o      <= 1'b0;
            ades_o      <= 1'b0;
            berr_o      <= 1'b0;
        end else begin
            done_o <= 1'b0;
            wreg_o <= 1'b0;
            adel_o <= 1'b0;
            ades_o <= 1'b0;
            berr_o <= 1'b0;
            if (accept) begin
                cnt_q <= '0;
                if (mis) begin
                    adel_o <= !is_st;
                    ades_o <= is_st;
                end else if (sc_fail) begin
                    done_o  <= 1'b1;
                    wreg_o  <= wreg_i;
                    wd_o    <= wd_i;
                    wdata_o <= '0;
                end else begin
                    op_q        <= op;
                    off_q       <= addr_i[1:0];
                    wd_q        <= wd_i;
                    wreg_q      <= wreg_i;
                    bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                    bus_sel_o   <= sel;
                    bus_wdata_o <= wdat;
                end
            end
            if (state == BUSY) begin
                cnt_q  <= cnt_q + CW'(1);
                kill_q <= kill;
                if (ack_ok) begin
                    done_o  <= 1'b1;
                    wreg_o  <= wreg_q && !st_q;
                    wd_o    <= wd_q;
                    wdata_o <= ld;
                end else if (tmo && !kill) begin
                    berr_o <= 1'b1;
                end
            end
            if (state == RESP) kill_q <= 1'b0;
            if (llbit_clr_i) llbit_q <= 1'b0;
            else if (ack_ok && LL_ENABLE && op_q == 4'd9) llbit_q <= 1'b1;
            else if (ack_ok && op_q == 4'd10) llbit_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: randomized scoreboard bench for mem_lsu against a behavioural model
module tb_mem_lsu;
    localparam int TO = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic valid_i = 1'b0, wreg_i = 1'b0, flush_i = 1'b0, llbit_clr_i = 1'b0;
    logic [3:0] op_i = '0;
    logic [31:0] addr_i = '0, reg2_i = '0, bus_rdata_i = '0;
    logic [4:0] wd_i = '0;
    logic bus_ack_i = 1'b0;
    logic bus_req_o, bus_we_o, stall_o, done_o, wreg_o, adel_o, ades_o, berr_o, llbit_o;
    logic [31:0] bus_addr_o, bus_wdata_o, wdata_o;
    logic [3:0] bus_sel_o;
    logic [4:0] wd_o;

    typedef struct packed {
        logic done, wreg, adel, ades, berr, llbit, we;
        logic [4:0] wd;
        logic [31:0] wdata, addr, wdat;
        logic [3:0] sel;
        logic [7:0] req_len;
    } exp_t;

    exp_t sb[$];
    int pass_cnt = 0, total = 0;
    int cur_lat = 0;
    bit ll = 1'b0;

    mem_lsu #(.ADDR_W(32), .TIMEOUT(TO), .LL_ENABLE(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i), .reg2_i(reg2_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .flush_i(flush_i), .llbit_clr_i(llbit_clr_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .stall_o(stall_o), .done_o(done_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .adel_o(adel_o), .ades_o(ades_o), .berr_o(berr_o), .llbit_o(llbit_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, want);
    endtask

    // Expected outcome of one access, derived from access size, offset and bus latency.
    function automatic exp_t model(int op, logic [31:0] a, logic [31:0] d, logic [4:0] wd, logic wr,
                                   logic [31:0] rd, int lat, bit kill);
        exp_t e;
        int size, off, busy;
        bit load;
        logic [31:0] v;
        e = '0;
        size = (op == 1 || op == 2 || op == 6) ? 1 : (op == 3 || op == 4 || op == 7) ? 2 : 4;
        load = op inside {1, 2, 3, 4, 5, 9};
        off = int'(a % 4);
        if (off % size != 0) begin
            e.adel = load;
            e.ades = !load;
            e.llbit = ll;
            return e;
        end
        if (op == 10 && !ll) begin
            e.done = 1'b1;
            e.wreg = wr;
            e.wd = wd;
            e.llbit = ll;
            return e;
        end
        busy = (lat >= 1 && lat <= TO) ? lat : TO;
        e.req_len = 8'(busy);
        e.we = !load;
        e.addr = a - off;
        e.sel = 4'(((1 << size) - 1) << (4 - off - size));
        e.wdat = size == 1 ? 32'(d[7:0]) * 32'h01010101 : size == 2 ? 32'(d[15:0]) * 32'h00010001 : d;
        if (!kill) begin
            if (lat < 1 || lat > TO) e.berr = 1'b1;
            else begin
                e.done = 1'b1;
                e.wreg = (load || op == 10) ? wr : 1'b0;
                e.wd = wd;
                v = rd >> (8 * (4 - off - size));
                if (size == 1) v = v % 256;
                if (size == 2) v = v % 65536;
                if (op == 1 && v >= 128) v = v - 256;
                if (op == 3 && v >= 32768) v = v - 65536;
                if (op == 10) v = 1;
                e.wdata = v;
                if (op == 9) ll = 1'b1;
                if (op == 10) ll = 1'b0;
            end
        end
        e.llbit = ll;
        return e;
    endfunction

    // Issued while the DUT is IDLE; returns after the response cycle with the DUT IDLE again.
    task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] d, input logic [31:0] rd,
                         input logic wr, input int lat, input bit flush);
        exp_t e;
        int fk, i;
        logic [4:0] wd;
        wd = 5'($urandom);
        e = model(op, a, d, wd, wr, rd, lat, flush);
        fk = (flush && e.req_len != 0) ? $urandom_range(1, int'(e.req_len)) : 0;
        cur_lat = lat;
        bus_rdata_i = rd;
        op_i = 4'(op);
        addr_i = a;
        reg2_i = d;
        wd_i = wd;
        wreg_i = wr;
        valid_i = 1'b1;
        sb.push_back(e);
        i = 0;
        do begin
            @(posedge clk);
            #1;
            i++;
            flush_i = (i == fk);
        end while (stall_o && i < 100);
        chk("resp_wait", stall_o, 0);
        flush_i = 1'b0;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic clr_ll();
        llbit_clr_i = 1'b1;
        @(posedge clk);
        #1;
        llbit_clr_i = 1'b0;
        ll = 1'b0;
        chk("llbit_clr", llbit_o, 0);
    endtask

    // Bus responder and scoreboard monitor: the response cycle is the first non-stalled cycle after a stall.
    initial begin
        bit prev = 1'b0, unstable = 1'b0;
        int n = 0, sn = 0;
        logic [68:0] first = '0;
        exp_t e;
        forever begin
            @(negedge clk);
            bus_ack_i = 1'b0;
            if (!rst) begin
                prev = 1'b0;
                n = 0;
                sn = 0;
                unstable = 1'b0;
            end else begin
                if (bus_req_o) begin
                    n++;
                    if (n == 1) first = {bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o};
                    else if (first != {bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o}) unstable = 1'b1;
                    bus_ack_i = (n == cur_lat);
                end
                if (stall_o) sn++;
                if (prev && !stall_o) begin
                    if (sb.size() == 0) chk("unexpected_resp", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("pulses", {done_o, wreg_o, adel_o, ades_o, berr_o}, {e.done, e.wreg, e.adel, e.ades, e.berr});
                        chk("llbit", llbit_o, e.llbit);
                        chk("req_len", n, e.req_len);
                        chk("stall_len", sn, e.req_len + 1);
                        chk("req_dropped", bus_req_o, 0);
                        if (e.done && e.wreg) chk("writeback", {wd_o, wdata_o}, {e.wd, e.wdata});
                        if (e.req_len != 0) begin
                            chk("bus_fields", {first[68], first[67:36], first[35:32]}, {e.we, e.addr, e.sel});
                            if (e.we) chk("bus_wdata", first[31:0], e.wdat);
                            chk("bus_stable", unstable, 0);
                        end
                    end
                    n = 0;
                    sn = 0;
                    unstable = 1'b0;
                end
                prev = stall_o;
            end
        end
    end

    initial begin
        int op, lat, r;
        logic [31:0] a;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus", {bus_req_o, bus_we_o, bus_sel_o, bus_addr_o}, 0);
        chk("rst_bus_wdata", bus_wdata_o, 0);
        chk("rst_ctl", {stall_o, done_o, wreg_o, adel_o, ades_o, berr_o, llbit_o, wd_o}, 0);
        chk("rst_wdata", wdata_o, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_op(1, 32'h101, 32'h0, 32'h11F23344, 1'b1, 3, 1'b0);
        do_op(7, 32'h202, 32'h0000ABCD, $urandom, 1'b1, 1, 1'b0);
        do_op(5, 32'h003, 32'h0, $urandom, 1'b1, 2, 1'b0);
        do_op(9, 32'h40, 32'h0, 32'hCAFEF00D, 1'b1, 2, 1'b0);
        do_op(10, 32'h40, 32'h1234, 32'h0, 1'b1, 2, 1'b0);
        do_op(10, 32'h40, 32'h1234, 32'h0, 1'b1, 2, 1'b0);
        do_op(5, 32'h80, 32'h0, $urandom, 1'b1, -1, 1'b0);
        do_op(5, 32'h84, 32'h0, $urandom, 1'b1, 16, 1'b0);
        do_op(5, 32'h88, 32'h0, $urandom, 1'b1, 4, 1'b1);
        do_op(9, 32'h40, 32'h0, $urandom, 1'b1, 1, 1'b0);
        clr_ll();
        valid_i = 1'b1;
        op_i = 4'd5;
        addr_i = 32'h0;
        flush_i = 1'b1;
        #1;
        chk("flush_idle_stall", stall_o, 0);
        @(posedge clk);
        #1;
        chk("flush_idle_req", {bus_req_o, stall_o}, 0);
        flush_i = 1'b0;
        op_i = 4'd12;
        #1;
        chk("none_op_stall", stall_o, 0);
        @(posedge clk);
        #1;
        chk("none_op_req", bus_req_o, 0);
        valid_i = 1'b0;
        for (int k = 0; k < 300; k++) begin
            op = $urandom_range(1, 10);
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom);
            r = $urandom_range(0, 19);
            lat = r < 16 ? 1 + r % 6 : r == 16 ? -1 : r == 17 ? 16 : r == 18 ? 15 : $urandom_range(1, 16);
            do_op(op, a, $urandom, $urandom, 1'($urandom), lat, $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) clr_ll();
        end
        do_op(9, 32'h100, 32'h0, $urandom, 1'b1, 1, 1'b0);
        chk("llbit_before_rst", llbit_o, 1);
        cur_lat = -1;
        op_i = 4'd5;
        addr_i = 32'h200;
        valid_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("busy_before_rst", bus_req_o, 1);
        valid_i = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_mid_req", bus_req_o, 0);
        chk("rst_mid_llbit", llbit_o, 0);
        chk("rst_mid_ctl", {stall_o, done_o, wreg_o, berr_o}, 0);
        ll = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        do_op(5, 32'h300, 32'h0, $urandom, 1'b1, 2, 1'b0);
        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
